// File: rtl/router_pkg.sv
// Shared types and helpers for the NUM_CH router control FSM.
package router_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        WAIT_TILL_EMPTY    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_e;

    // Bits needed to hold 0..wait_max; never less than one bit.
    function automatic int unsigned wait_cnt_w(input int unsigned wait_max);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < (64'(wait_max) + 64'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating wait counter: counts while enabled, clears otherwise, and flags
// the last permitted cycle (WAIT_MAX-1). WAIT_MAX == 0 disables the flag.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 30
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned       CNT_W   = wait_cnt_w(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0]  CNT_TC  = CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear when idle, increment while enabled, hold at saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (WAIT_MAX != 0) && en_i && (cnt_q == CNT_TC);

endmodule

// File: rtl/router_fsm_nch.sv
// Router control FSM for NUM_CH output channels: decodes the header address,
// sequences FIFO writes, drops invalid-address packets and bounds the wait
// for a busy destination FIFO.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned WAIT_MAX = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              drop_state,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] ch_sel
);

    // Channel vectors are widened to the full address space so that an
    // out-of-range address indexes a zero bit instead of going out of bounds.
    localparam int unsigned       CH_SPACE = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

    logic [CH_SPACE-1:0] empty_ext, full_ext, srst_ext;
    logic                addr_valid;
    logic                wait_tc;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ch_sel_q, ch_sel_d;

    assign empty_ext  = CH_SPACE'(fifo_empty);
    assign full_ext   = CH_SPACE'(fifo_full);
    assign srst_ext   = CH_SPACE'(soft_reset);
    assign addr_valid = ({1'b0, data_in} < NUM_CH_W);
    assign ch_sel     = ch_sel_q;

    router_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (state_q == WAIT_TILL_EMPTY),
        .tc_o  (wait_tc)
    );

    // Next-state and channel-select logic; soft reset of the selected channel
    // overrides every normal transition outside DECODE_ADDRESS.
    always_comb begin
        state_d  = state_q;
        ch_sel_d = ch_sel_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    ch_sel_d = data_in;
                    if (!addr_valid)              state_d = DROP_PACKET;
                    else if (empty_ext[data_in])  state_d = LOAD_FIRST_DATA;
                    else                          state_d = WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (full_ext[ch_sel_q])  state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)     state_d = LOAD_PARITY;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE: begin
                if (!full_ext[ch_sel_q]) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)         state_d = DECODE_ADDRESS;
                else if (low_pkt_valid)  state_d = LOAD_PARITY;
                else                     state_d = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[ch_sel_q]) state_d = LOAD_FIRST_DATA;
                else if (wait_tc)        state_d = DROP_PACKET;
            end
            CHECK_PARITY_ERROR: begin
                if (full_ext[ch_sel_q])  state_d = FIFO_FULL_STATE;
                else                     state_d = DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!pkt_valid)          state_d = DECODE_ADDRESS;
            end
            default:            state_d = DECODE_ADDRESS;
        endcase
        if ((state_q != DECODE_ADDRESS) && srst_ext[ch_sel_q]) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // State and channel-select registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= DECODE_ADDRESS;
            ch_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_sel_q <= ch_sel_d;
        end
    end

    // Moore output decode; timeout_err is the only input-qualified strobe.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        drop_state    = 1'b0;
        timeout_err   = 1'b0;
        case (state_q)
            DECODE_ADDRESS:     detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                busy        = 1'b1;
                timeout_err = wait_tc && !empty_ext[ch_sel_q];
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            DROP_PACKET:        drop_state = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch (NUM_CH=3, ADDR_W=2, WAIT_MAX=8).
module tb_router_fsm_nch;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full, fifo_empty, soft_reset;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, drop_state, timeout_err;
    logic [1:0] ch_sel;

    int checks   = 0;
    int failures = 0;

    // Output vector order: da lfd ld laf ffs rst_int wen busy drop tmo
    localparam logic [9:0] O_DA  = 10'b1000000000;
    localparam logic [9:0] O_LFD = 10'b0100000100;
    localparam logic [9:0] O_LD  = 10'b0010001000;
    localparam logic [9:0] O_LP  = 10'b0000001100;
    localparam logic [9:0] O_FFS = 10'b0000100100;
    localparam logic [9:0] O_LAF = 10'b0001001100;
    localparam logic [9:0] O_WT  = 10'b0000000100;
    localparam logic [9:0] O_TMO = 10'b0000000101;
    localparam logic [9:0] O_CPE = 10'b0000010100;
    localparam logic [9:0] O_DR  = 10'b0000000010;
    localparam logic [2:0] Z3    = 3'b000;

    logic [9:0] obs;
    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, write_enb_reg, busy, drop_state, timeout_err};

    typedef struct packed {
        logic       pv;
        logic [1:0] din;
        logic [2:0] emp;
        logic [2:0] full;
        logic [2:0] srst;
        logic       pd;
        logic       lpv;
        logic [9:0] e;
    } stim_t;

    router_fsm_nch #(
        .NUM_CH   (3),
        .ADDR_W   (2),
        .WAIT_MAX (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy),
        .drop_state    (drop_state),
        .timeout_err   (timeout_err),
        .ch_sel        (ch_sel)
    );

    always #5 clock = ~clock;

    function automatic stim_t S(input logic pv, input logic [1:0] din,
                                input logic [2:0] emp, input logic [2:0] full,
                                input logic [2:0] srst, input logic pd,
                                input logic lpv, input logic [9:0] e);
        return '{pv, din, emp, full, srst, pd, lpv, e};
    endfunction

    task automatic drive(input stim_t s);
        pkt_valid     = s.pv;
        data_in       = s.din;
        fifo_empty    = s.emp;
        fifo_full     = s.full;
        soft_reset    = s.srst;
        parity_done   = s.pd;
        low_pkt_valid = s.lpv;
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(S(1'b1, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA));
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (obs !== O_DA) begin
            failures++;
            $display("FAIL reset_outs out=%b exp=%b", obs, O_DA);
        end
        checks++;
        if (ch_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_ch_sel got=%0d exp=0", ch_sel);
        end
        drive(S(1'b0, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA));
        reset = 1'b0;
    endtask

    task automatic test_basic;
        stim_t v[9];
        int    wen = 0;
        v[0] = S(1'b1, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        v[1] = S(1'b1, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LFD);
        v[2] = S(1'b1, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LD);
        v[3] = S(1'b1, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LD);
        v[4] = S(1'b1, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LD);
        v[5] = S(1'b0, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LD);
        v[6] = S(1'b0, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LP);
        v[7] = S(1'b0, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_CPE);
        v[8] = S(1'b0, 2'd2, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        for (int i = 0; i < 9; i++) begin
            cyc();
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].e) begin
                failures++;
                $display("FAIL basic[%0d] out=%b exp=%b", i, obs, v[i].e);
            end
            if (write_enb_reg === 1'b1) wen++;
        end
        checks++;
        if (wen != 5) begin
            failures++;
            $display("FAIL basic_wen_cycles got=%0d exp=5", wen);
        end
        checks++;
        if (ch_sel !== 2'd2) begin
            failures++;
            $display("FAIL basic_ch_sel got=%0d exp=2", ch_sel);
        end
    endtask

    task automatic test_wait;
        stim_t v[11];
        v[0]  = S(1'b1, 2'd1, 3'b101, Z3, Z3, 1'b0, 1'b0, O_DA);
        v[1]  = S(1'b1, 2'd1, 3'b101, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[2]  = S(1'b1, 2'd1, 3'b100, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[3]  = S(1'b1, 2'd1, 3'b101, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[4]  = S(1'b1, 2'd1, 3'b100, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[5]  = S(1'b1, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[6]  = S(1'b1, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LFD);
        v[7]  = S(1'b0, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LD);
        v[8]  = S(1'b0, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LP);
        v[9]  = S(1'b0, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_CPE);
        v[10] = S(1'b0, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        for (int i = 0; i < 11; i++) begin
            cyc();
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].e) begin
                failures++;
                $display("FAIL wait[%0d] out=%b exp=%b", i, obs, v[i].e);
            end
        end
        checks++;
        if (ch_sel !== 2'd1) begin
            failures++;
            $display("FAIL wait_ch_sel got=%0d exp=1", ch_sel);
        end
    endtask

    task automatic test_timeout;
        stim_t v[26];
        int    wen = 0;
        v[0] = S(1'b1, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_DA);
        for (int i = 1; i < 8; i++) v[i] = S(1'b1, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[8]  = S(1'b1, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_TMO);
        v[9]  = S(1'b1, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_DR);
        v[10] = S(1'b0, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_DR);
        v[11] = S(1'b0, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_DA);
        // Second wait: channel empties in the terminal-count cycle.
        v[12] = S(1'b1, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_DA);
        for (int i = 13; i < 20; i++) v[i] = S(1'b1, 2'd0, 3'b110, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[20] = S(1'b1, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_WT);
        v[21] = S(1'b1, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LFD);
        v[22] = S(1'b0, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LD);
        v[23] = S(1'b0, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_LP);
        v[24] = S(1'b0, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_CPE);
        v[25] = S(1'b0, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        for (int i = 0; i < 26; i++) begin
            cyc();
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].e) begin
                failures++;
                $display("FAIL timeout[%0d] out=%b exp=%b", i, obs, v[i].e);
            end
            if (i < 12 && write_enb_reg === 1'b1) wen++;
        end
        checks++;
        if (wen != 0) begin
            failures++;
            $display("FAIL timeout_no_write got=%0d exp=0", wen);
        end
    endtask

    task automatic test_invalid;
        stim_t v[5];
        int    wen = 0;
        v[0] = S(1'b1, 2'd3, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        v[1] = S(1'b1, 2'd3, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DR);
        v[2] = S(1'b0, 2'd3, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DR);
        v[3] = S(1'b0, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        v[4] = S(1'b0, 2'd1, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA);
        for (int i = 0; i < 5; i++) begin
            cyc();
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].e) begin
                failures++;
                $display("FAIL invalid[%0d] out=%b exp=%b", i, obs, v[i].e);
            end
            if (write_enb_reg === 1'b1) wen++;
        end
        checks++;
        if (wen != 0) begin
            failures++;
            $display("FAIL invalid_no_write got=%0d exp=0", wen);
        end
        checks++;
        if (ch_sel !== 2'd3) begin
            failures++;
            $display("FAIL invalid_ch_sel got=%0d exp=3", ch_sel);
        end
    endtask

    task automatic test_full;
        stim_t v[11];
        v[0]  = S(1'b1, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b0, O_DA);
        v[1]  = S(1'b1, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b0, O_LFD);
        v[2]  = S(1'b1, 2'd1, 3'b111, 3'b101, Z3, 1'b0, 1'b0, O_LD);
        v[3]  = S(1'b1, 2'd1, 3'b111, 3'b010, Z3, 1'b0, 1'b0, O_LD);
        v[4]  = S(1'b1, 2'd1, 3'b111, 3'b010, Z3, 1'b0, 1'b0, O_FFS);
        v[5]  = S(1'b1, 2'd1, 3'b111, 3'b010, Z3, 1'b0, 1'b0, O_FFS);
        v[6]  = S(1'b1, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b0, O_FFS);
        v[7]  = S(1'b1, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b1, O_LAF);
        v[8]  = S(1'b0, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b0, O_LP);
        v[9]  = S(1'b0, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b0, O_CPE);
        v[10] = S(1'b0, 2'd1, 3'b111, Z3,     Z3, 1'b0, 1'b0, O_DA);
        for (int i = 0; i < 11; i++) begin
            cyc();
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].e) begin
                failures++;
                $display("FAIL full[%0d] out=%b exp=%b", i, obs, v[i].e);
            end
        end
    endtask

    task automatic test_soft_reset;
        stim_t v[10];
        v[0] = S(1'b1, 2'd2, 3'b111, Z3,     Z3,     1'b0, 1'b0, O_DA);
        v[1] = S(1'b1, 2'd2, 3'b111, Z3,     Z3,     1'b0, 1'b0, O_LFD);
        v[2] = S(1'b1, 2'd2, 3'b111, Z3,     3'b001, 1'b0, 1'b0, O_LD);
        v[3] = S(1'b1, 2'd2, 3'b111, Z3,     3'b001, 1'b0, 1'b0, O_LD);
        v[4] = S(1'b1, 2'd2, 3'b111, Z3,     3'b100, 1'b0, 1'b0, O_LD);
        v[5] = S(1'b1, 2'd1, 3'b111, Z3,     Z3,     1'b0, 1'b0, O_DA);
        v[6] = S(1'b1, 2'd1, 3'b111, Z3,     Z3,     1'b0, 1'b0, O_LFD);
        v[7] = S(1'b1, 2'd1, 3'b111, 3'b010, Z3,     1'b0, 1'b0, O_LD);
        v[8] = S(1'b1, 2'd1, 3'b111, Z3,     Z3,     1'b0, 1'b0, O_FFS);
        v[9] = S(1'b1, 2'd1, 3'b111, Z3,     Z3,     1'b0, 1'b0, O_LAF);
        for (int i = 0; i < 10; i++) begin
            cyc();
            drive(v[i]);
            #1;
            checks++;
            if (obs !== v[i].e) begin
                failures++;
                $display("FAIL soft_reset[%0d] out=%b exp=%b", i, obs, v[i].e);
            end
        end
        // Asynchronous reset in the middle of LOAD_AFTER_FULL, between edges.
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== O_DA) begin
            failures++;
            $display("FAIL async_reset_outs out=%b exp=%b", obs, O_DA);
        end
        checks++;
        if (ch_sel !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_ch_sel got=%0d exp=0", ch_sel);
        end
        drive(S(1'b0, 2'd0, 3'b111, Z3, Z3, 1'b0, 1'b0, O_DA));
        #1;
        reset = 1'b0;
        cyc();
        checks++;
        if (obs !== O_DA) begin
            failures++;
            $display("FAIL post_reset_idle out=%b exp=%b", obs, O_DA);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_timeout();
        test_invalid();
        test_full();
        test_soft_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
